time_of_day_clock: RTL and testbench

- Wall-clock time source that sits directly upstream of the traffic light controller.
- Drives that controller's 5-bit `hours` and 6-bit `minutes` inputs, plus a registered `day_mode` flag matching the controller's day window (05:00 to 09:00 inclusive).
- Counts seconds, minutes and hours from a clock-cycle prescaler.
- Supports pausing and a validated time-set load from a supervisor.

---
 rtl/time_of_day_clock.sv | 125 ++++++++++++
 tb/tb_time_of_day_clock.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_clock.sv
// Wall-clock time source: prescaled seconds/minutes/hours counter with a validated
// supervisor time-set load and a registered day-window flag for the traffic controller.
module time_of_day_clock #(
  parameter int CLKS_PER_SEC  = 10,
  parameter int RESET_HOURS   = 0,
  parameter int RESET_MINUTES = 0
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       run,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  output logic       set_ack,
  output logic       set_err,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_tick,
  output logic       day_mode
);

  localparam int              PRE_W   = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [4:0]       RST_H   = 5'(RESET_HOURS);
  localparam logic [5:0]       RST_M   = 6'(RESET_MINUTES);

  // Controller day window: 05:00 through 09:00 inclusive.
  function automatic logic day_window(input logic [4:0] h, input logic [5:0] m);
    day_window = ((h >= 5'd5) && (h <= 5'd8)) || ((h == 5'd9) && (m == 6'd0));
  endfunction

  logic [PRE_W-1:0] r_pre;
  logic [4:0]       r_hours;
  logic [5:0]       r_minutes;
  logic [5:0]       r_seconds;
  logic             r_sec_tick;
  logic             r_min_tick;
  logic             r_day_tick;
  logic             r_set_ack;
  logic             r_set_err;
  logic             r_day_mode;

  logic             w_set_ok;
  logic             w_adv;
  logic             w_sec_wrap;
  logic             w_min_wrap;
  logic             w_day_wrap;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [4:0]       w_hr_nxt;
  logic [5:0]       w_min_nxt;
  logic [5:0]       w_sec_nxt;

  // Next-state: a valid set overrides and discards any coincident second advance.
  always_comb begin
    w_set_ok   = set_valid && (set_hours <= 5'd23) && (set_minutes <= 6'd59);
    w_sec_wrap = (r_seconds == 6'd59);
    w_min_wrap = w_sec_wrap && (r_minutes == 6'd59);
    w_day_wrap = w_min_wrap && (r_hours == 5'd23);
    w_adv      = 1'b0;
    w_pre_nxt  = r_pre;
    w_hr_nxt   = r_hours;
    w_min_nxt  = r_minutes;
    w_sec_nxt  = r_seconds;
    if (w_set_ok) begin
      w_pre_nxt = '0;
      w_hr_nxt  = set_hours;
      w_min_nxt = set_minutes;
      w_sec_nxt = 6'd0;
    end else if (run) begin
      if (r_pre == PRE_MAX) begin
        w_pre_nxt = '0;
        w_adv     = 1'b1;
        w_sec_nxt = w_sec_wrap ? 6'd0 : (r_seconds + 6'd1);
        w_min_nxt = w_sec_wrap ? ((r_minutes == 6'd59) ? 6'd0 : (r_minutes + 6'd1)) : r_minutes;
        w_hr_nxt  = w_min_wrap ? ((r_hours == 5'd23) ? 5'd0 : (r_hours + 5'd1)) : r_hours;
      end else begin
        w_pre_nxt = r_pre + PRE_ONE;
      end
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  // State and pulse registers; day_mode tracks next-state time so it never lags.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pre      <= '0;
      r_hours    <= RST_H;
      r_minutes  <= RST_M;
      r_seconds  <= 6'd0;
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_set_ack  <= 1'b0;
      r_set_err  <= 1'b0;
      r_day_mode <= day_window(RST_H, RST_M);
    end else begin
      r_pre      <= w_pre_nxt;
      r_hours    <= w_hr_nxt;
      r_minutes  <= w_min_nxt;
      r_seconds  <= w_sec_nxt;
      r_sec_tick <= w_adv;
      r_min_tick <= w_adv && w_sec_wrap;
      r_day_tick <= w_adv && w_day_wrap;
      r_set_ack  <= w_set_ok;
      r_set_err  <= set_valid && !w_set_ok;
      r_day_mode <= day_window(w_hr_nxt, w_min_nxt);
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign sec_tick = r_sec_tick;
  assign min_tick = r_min_tick;
  assign day_tick = r_day_tick;
  assign set_ack  = r_set_ack;
  assign set_err  = r_set_err;
  assign day_mode = r_day_mode;

endmodule

// File: tb/tb_time_of_day_clock.sv
// Scoreboard bench for time_of_day_clock: stimulus pushes expected pulse events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_time_of_day_clock;

  localparam int CPS = 4;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hours = 5'd0;
  logic [5:0] set_minutes = 6'd0;
  logic       set_ack, set_err, sec_tick, min_tick, day_tick, day_mode;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;

  time_of_day_clock #(.CLKS_PER_SEC(CPS), .RESET_HOURS(0), .RESET_MINUTES(0)) dut (
    .clock(clock), .clear(clear), .run(run), .set_valid(set_valid),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_ack(set_ack),
    .set_err(set_err), .hours(hours), .minutes(minutes), .seconds(seconds),
    .sec_tick(sec_tick), .min_tick(min_tick), .day_tick(day_tick), .day_mode(day_mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    int edge_n; int h; int m; int s; int sec; int mn; int day; int ack; int err; int dm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_no = 0;
  int   mpre = 0, mh = 0, mm = 0, ms = 0;
  int   dm_ok;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; expected pulse events are queued for the monitor.
  task automatic step(input logic r, input logic sv, input int sh, input int sm);
    logic ok;
    exp_t x;
    run = r; set_valid = sv; set_hours = 5'(sh); set_minutes = 6'(sm);
    @(posedge clock);
    #1;
    edge_no++;
    ok = sv && (sh <= 23) && (sm <= 59);
    x = '{default: 0};
    x.edge_n = edge_no;
    if (ok) begin
      mh = sh; mm = sm; ms = 0; mpre = 0; x.ack = 1;
    end else if (r) begin
      if (mpre == CPS - 1) begin
        mpre = 0; x.sec = 1;
        if (ms == 59) begin
          ms = 0; x.mn = 1;
          if (mm == 59) begin
            mm = 0;
            if (mh == 23) begin mh = 0; x.day = 1; end
            else mh = mh + 1;
          end else mm = mm + 1;
        end else ms = ms + 1;
      end else mpre = mpre + 1;
    end
    x.err = (sv && !ok) ? 1 : 0;
    x.h = mh; x.m = mm; x.s = ms;
    x.dm = (((mh >= 5) && (mh <= 8)) || ((mh == 9) && (mm == 0))) ? 1 : 0;
    if ((x.sec != 0) || (x.ack != 0) || (x.err != 0)) sb_q.push_back(x);
    @(negedge clock);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  // Monitor: every DUT pulse must match the next queued expectation exactly.
  always @(negedge clock) begin
    if (clear && (sec_tick || min_tick || day_tick || set_ack || set_err)) begin
      vectors++;
      mon_a = '{edge_no, int'(hours), int'(minutes), int'(seconds), int'(sec_tick),
                int'(min_tick), int'(day_tick), int'(set_ack), int'(set_err), int'(day_mode)};
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: edge %0d got %0d:%0d:%0d sec/min/day=%0d%0d%0d ack=%0d err=%0d, expected no pulse",
                 mon_a.edge_n, mon_a.h, mon_a.m, mon_a.s, mon_a.sec, mon_a.mn, mon_a.day, mon_a.ack, mon_a.err);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_a.edge_n != mon_e.edge_n || mon_a.h != mon_e.h || mon_a.m != mon_e.m ||
            mon_a.s != mon_e.s || mon_a.sec != mon_e.sec || mon_a.mn != mon_e.mn ||
            mon_a.day != mon_e.day || mon_a.ack != mon_e.ack || mon_a.err != mon_e.err ||
            mon_a.dm != mon_e.dm) begin
          miscompares++;
          $display("FAIL pulse_event: got edge %0d %0d:%0d:%0d t=%0d%0d%0d a=%0d e=%0d dm=%0d, expected edge %0d %0d:%0d:%0d t=%0d%0d%0d a=%0d e=%0d dm=%0d",
                   mon_a.edge_n, mon_a.h, mon_a.m, mon_a.s, mon_a.sec, mon_a.mn, mon_a.day, mon_a.ack, mon_a.err, mon_a.dm,
                   mon_e.edge_n, mon_e.h, mon_e.m, mon_e.s, mon_e.sec, mon_e.mn, mon_e.day, mon_e.ack, mon_e.err, mon_e.dm);
        end
      end
    end
  end

  initial begin
    run = 1'b1;
    #22;
    check("reset_hours", hours, 0);
    check("reset_minutes", minutes, 0);
    check("reset_seconds", seconds, 0);
    check("reset_sec_tick", sec_tick, 0);
    check("reset_day_mode", day_mode, 0);
    @(negedge clock);
    clear = 1'b1;

    // 1: first second on the 4th edge, then every 4th edge
    step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0);
    check("t1_sec_before", seconds, 0);
    check("t1_tick_before", sec_tick, 0);
    step(1'b1, 1'b0, 0, 0);
    check("t1_sec_4th", seconds, 1);
    check("t1_tick_4th", sec_tick, 1);
    run_n(8);

    // 2: day window entry and exit
    step(1'b1, 1'b1, 4, 59);
    check("t2_set_hours", hours, 4);
    check("t2_set_minutes", minutes, 59);
    check("t2_set_ack", set_ack, 1);
    run_n(239);
    check("t2_0459_59_sec", seconds, 59);
    check("t2_0459_59_dm", day_mode, 0);
    step(1'b1, 1'b0, 0, 0);
    check("t2_0500_hours", hours, 5);
    check("t2_0500_minutes", minutes, 0);
    check("t2_0500_min_tick", min_tick, 1);
    check("t2_0500_dm", day_mode, 1);
    step(1'b1, 1'b1, 9, 0);
    check("t2_0900_dm", day_mode, 1);
    dm_ok = 1;
    for (int i = 0; i < 239; i++) begin
      step(1'b1, 1'b0, 0, 0);
      if (day_mode !== 1'b1) dm_ok = 0;
    end
    check("t2_dm_through_0900", dm_ok, 1);
    step(1'b1, 1'b0, 0, 0);
    check("t2_0901_minutes", minutes, 1);
    check("t2_0901_dm", day_mode, 0);

    // 3: midnight wrap
    step(1'b1, 1'b1, 23, 59);
    run_n(239);
    step(1'b1, 1'b0, 0, 0);
    check("t3_wrap_hours", hours, 0);
    check("t3_wrap_minutes", minutes, 0);
    check("t3_wrap_seconds", seconds, 0);
    check("t3_day_tick", day_tick, 1);
    check("t3_min_tick", min_tick, 1);
    check("t3_dm", day_mode, 0);
    step(1'b1, 1'b0, 0, 0);
    check("t3_day_tick_1cyc", day_tick, 0);

    // 4: rejected and accepted sets
    step(1'b1, 1'b1, 24, 10);
    check("t4_err_hours", set_err, 1);
    check("t4_err_no_ack", set_ack, 0);
    check("t4_err_time_kept", hours, 0);
    step(1'b1, 1'b1, 7, 60);
    check("t4_err_minutes", set_err, 1);
    step(1'b1, 1'b1, 7, 30);
    check("t4_ack", set_ack, 1);
    check("t4_hours", hours, 7);
    check("t4_minutes", minutes, 30);
    check("t4_dm", day_mode, 1);

    // 5: set coincident with a second advance
    step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 12, 34);
    check("t5_hours", hours, 12);
    check("t5_seconds", seconds, 0);
    check("t5_no_sec_tick", sec_tick, 0);
    run_n(4);
    check("t5_next_tick", sec_tick, 1);
    check("t5_next_sec", seconds, 1);

    // 6: pause mid-second, then asynchronous clear
    run_n(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 0);
    check("t6_frozen_seconds", seconds, 1);
    check("t6_frozen_minutes", minutes, 34);
    run_n(3);
    check("t6_resumed_seconds", seconds, 2);
    #2;
    clear = 1'b0;
    #1;
    check("t6_async_hours", hours, 0);
    check("t6_async_minutes", minutes, 0);
    check("t6_async_seconds", seconds, 0);
    mh = 0; mm = 0; ms = 0; mpre = 0;
    @(negedge clock);
    clear = 1'b1;
    run_n(4);
    check("t6_after_clear_sec", seconds, 1);

    @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
